wbi_slv_stg: RTL and testbench
==============================

// Module: wbi_slv_stg
// PURPOSE
// - Registered slave-side stage of the wishbone interconnect; sits between the granted-master bus and one slave.
// - Accepts a classic-cycle request from the interconnect.
// - Replays the request to the slave and waits for the slave's ack/err.
// - Returns a single-cycle ack/err with read data to the master.
// - Optional bus-timeout watchdog converts a hung slave access into an error response.
// PARAMETERS
// AW       32   address width
// DW       32   data width; byte-select width = DW/8
// TMO_CYC  255  slave wait cycles before timeout error (only with WBI_TIMEOUT_EN); counter width $clog2(TMO_CYC+1)
// PORTS
// clk       in   1       clock
// rstn      in   1       asynchronous active-low reset
// m_cyc_i   in   1       master cycle valid
// m_stb_i   in   1       master strobe
// m_we_i    in   1       master write enable
// m_adr_i   in   AW      master address
// m_dat_i   in   DW      master write data
// m_sel_i   in   DW/8    master byte select
// m_dat_o   out  DW      read data to master
// m_ack_o   out  1       ack to master, 1-cycle pulse
// m_err_o   out  1       error to master, 1-cycle pulse
// s_cyc_o   out  1       slave cycle valid
// s_stb_o   out  1       slave strobe
// s_we_o    out  1       slave write enable
// s_adr_o   out  AW      slave address
// s_dat_o   out  DW      slave write data
// s_sel_o   out  DW/8    slave byte select
// s_dat_i   in   DW      slave read data
// s_ack_i   in   1       slave ack
// s_err_i   in   1       slave error
// busy_o    out  1       high in REQ or RESP
// BEHAVIOUR
// - Reset:
//   - all outputs 0; state IDLE; timeout counter 0.
// - IDLE:
//   - when m_cyc_i & m_stb_i, register we/adr/dat/sel onto s_* outputs.
//   - set s_cyc_o = s_stb_o = 1 and go to REQ.
//   - the slave sees the request 1 cycle after the master strobe.
// - REQ:
//   - hold s_* stable until s_ack_i or s_err_i is sampled high.
//   - on that edge: capture s_dat_i into m_dat_o (read only; writes leave m_dat_o unchanged).
//   - on that edge: clear s_cyc_o/s_stb_o.
//   - on that edge: go to RESP with an ack or err flag.
//   - s_err_i and s_ack_i high together: err wins.
// - RESP:
//   - assert m_ack_o or m_err_o for exactly 1 cycle, then return to IDLE.
//   - a new master request is accepted in the cycle after RESP.
// - Latency with a zero-wait slave (ack combinational in its first stb cycle):
//   - m_ack_o is high 2 cycles after m_stb_i is first sampled.
//   - each slave wait state adds 1 cycle.
// - Abort:
//   - m_cyc_i low while in REQ: clear s_cyc_o/s_stb_o next edge and go to IDLE.
//   - no m_ack_o/m_err_o is issued.
//   - a slave ack arriving in the abort cycle is discarded.
// - m_cyc_i low in RESP: the pulse is still issued (1 cycle) and the master ignores it.
// - Reset asserted mid-transfer:
//   - immediate return to IDLE with all outputs 0.
//   - no pending response survives reset.
// - m_dat_o holds its last captured value between transfers.
// CONFIGURATION
// - WBI_TIMEOUT_EN defined:
//   - the counter clears on entry to REQ and increments each REQ cycle without ack/err.
//   - when the count reaches TMO_CYC: clear s_cyc_o/s_stb_o, set m_dat_o to all-ones, go to RESP with err (m_err_o pulse).
//   - a slave ack/err in the same cycle as the timeout wins over the timeout.
// - WBI_TIMEOUT_EN undefined:
//   - no counter is built; REQ waits indefinitely for s_ack_i/s_err_i.
// TESTING
// 1) Read, zero-wait slave:
//    - stimulus: m_stb_i@c0, adr=0x100, s_ack_i with s_dat_i=0xA5A5_5A5A during c1.
//    - response: s_stb_o high c1 only; m_ack_o high c2 only; m_dat_o=0xA5A5_5A5A.
// 2) Write, 3 wait states:
//    - stimulus: we=1, dat=0x1234_5678, sel=4'b0011.
//    - response: s_* stable c1..c4; m_ack_o c5; m_dat_o unchanged.
// 3) Slave error:
//    - stimulus: s_err_i=1 and s_ack_i=1 together in c2.
//    - response: m_err_o high c3; m_ack_o stays 0.
// 4) Abort:
//    - stimulus: m_cyc_i dropped in c2 while REQ; s_ack_i high in c2.
//    - response: s_cyc_o=0 c3; no m_ack_o/m_err_o; next request accepted normally.
// 5) Timeout (WBI_TIMEOUT_EN, TMO_CYC=8):
//    - stimulus: slave never acks.
//    - response: s_stb_o drops after 8 REQ cycles; m_err_o 1-cycle pulse; m_dat_o=0xFFFF_FFFF.
//    - without the macro the bench sees busy_o held high for 1000 cycles.
// 6) Reset mid-transfer:
//    - stimulus: rstn low during REQ.
//    - response: all outputs 0 asynchronously; first transfer after release completes as in 1).

Source files
------------

// File: rtl/wbi_slv_stg_if.sv
// Classic-cycle wishbone bus bundle. The master modport drives the request
// side, and the slave modport returns data/ack/err.
interface wbi_slv_stg_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;

  modport master (output cyc, stb, we, adr, dat_w, sel, input  dat_r, ack, err);
  modport slave  (input  cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/wbi_slv_stg.sv
module wbi_slv_stg #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 255
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            m_cyc_i,
  input  logic            m_stb_i,
  input  logic            m_we_i,
  input  logic [AW-1:0]   m_adr_i,
  input  logic [DW-1:0]   m_dat_i,
  input  logic [DW/8-1:0] m_sel_i,
  output logic [DW-1:0]   m_dat_o,
  output logic            m_ack_o,
  output logic            m_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} st_t;
  st_t st;

`ifdef WBI_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_nxt;
  logic          tmo_hit;
  assign tmo_nxt = tmo_cnt + CW'(1);
  assign tmo_hit = (tmo_nxt == CW'(TMO_CYC));
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st      <= IDLE;
      s_cyc_o <= 1'b0;
      s_stb_o <= 1'b0;
      s_we_o  <= 1'b0;
      s_adr_o <= '0;
      s_dat_o <= '0;
      s_sel_o <= '0;
      m_dat_o <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      busy_o  <= 1'b0;
`ifdef WBI_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      case (st)
        IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            s_we_o  <= m_we_i;
            s_adr_o <= m_adr_i;
            s_dat_o <= m_dat_i;
            s_sel_o <= m_sel_i;
            s_cyc_o <= 1'b1;
            s_stb_o <= 1'b1;
            busy_o  <= 1'b1;
            st      <= REQ;
`ifdef WBI_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        REQ: begin
          if (!m_cyc_i) begin
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
            busy_o  <= 1'b0;
            st      <= IDLE;
          end else if (s_ack_i || s_err_i) begin
            if (!s_we_o) m_dat_o <= s_dat_i;
            m_err_o <= s_err_i;
            m_ack_o <= !s_err_i;
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
            st      <= RESP;
          end
`ifdef WBI_TIMEOUT_EN
          else if (tmo_hit) begin
            m_dat_o <= '1;
            m_err_o <= 1'b1;
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
            st      <= RESP;
          end else begin
            tmo_cnt <= tmo_nxt;
          end
`endif
        end
        RESP: begin
          busy_o <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbi_slv_stg.sv
module tb_wbi_slv_stg;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy;
  int   cyc_n = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat_w, m_dat;
  logic [3:0]  m_sel;
  logic        m_ack, m_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;

  wbi_slv_stg #(.AW(32), .DW(32), .TMO_CYC(8)) dut (
    .clk(clk), .rstn(rstn),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
    .m_dat_i(m_dat_w), .m_sel_i(m_sel), .m_dat_o(m_dat), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_dat_w), .s_sel_o(s_sel), .s_dat_i(s_dat_r), .s_ack_i(s_ack), .s_err_i(s_err),
    .busy_o(busy)
  );

  typedef struct {
    logic        err;
    logic [31:0] dat;
    bit          chk_dat;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we;
    m_adr = adr;  m_dat_w = dat; m_sel = sel;
  endtask

  task automatic idle_m();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
  endtask

  task automatic push(input logic err, input logic [31:0] dat, input bit chk_dat, input int due);
    exp_t e;
    e.err = err; e.dat = dat; e.chk_dat = chk_dat; e.due = due;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rstn && (m_ack || m_err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected ack=%b err=%b cyc=%0d", m_ack, m_err, cyc_n);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (m_err !== e.err || m_ack !== ~e.err || cyc_n != e.due ||
            (e.chk_dat && m_dat !== e.dat)) begin
          errors++;
          $display("FAIL resp ack=%b err=%b dat=%h cyc=%0d exp err=%b dat=%h cyc=%0d",
                   m_ack, m_err, m_dat, cyc_n, e.err, e.dat, e.due);
        end
      end
    end
  end

  initial begin
    int t0;
    int low;
    idle_m();
    m_adr = '0; m_dat_w = '0; m_sel = '0;
    s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;

    tick(); tick();
    chk("rst_state", {27'd0, busy, s_cyc, s_stb, m_ack, m_err}, 32'd0);
    chk("rst_dat", m_dat, 32'd0);
    rstn = 1'b1;
    tick();

    t0 = cyc_n;
    req(1'b0, 32'h100, 32'h0, 4'hf);
    push(1'b0, 32'hA5A5_5A5A, 1'b1, t0 + 2);
    tick();
    chk("t1_stb_c1", s_stb, 1'b1);
    chk("t1_adr_c1", s_adr, 32'h100);
    s_ack = 1'b1; s_dat_r = 32'hA5A5_5A5A;
    tick();
    s_ack = 1'b0; s_dat_r = '0;
    idle_m();
    chk("t1_stb_c2", s_stb, 1'b0);
    tick();
    chk("t1_busy_c3", busy, 1'b0);
    chk("t1_dat_hold", m_dat, 32'hA5A5_5A5A);

    t0 = cyc_n;
    req(1'b1, 32'h200, 32'h1234_5678, 4'b0011);
    push(1'b0, 32'hA5A5_5A5A, 1'b1, t0 + 5);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t2_s_stable", {s_stb, s_we, s_sel, s_adr[25:0]}, {1'b1, 1'b1, 4'b0011, 26'h200});
      chk("t2_s_dat", s_dat_w, 32'h1234_5678);
      if (i == 4) s_ack = 1'b1;
    end
    tick();
    s_ack = 1'b0;
    idle_m();
    chk("t2_stb_c5", s_stb, 1'b0);
    tick();

    t0 = cyc_n;
    req(1'b0, 32'h300, 32'h0, 4'hf);
    push(1'b1, 32'h0, 1'b0, t0 + 3);
    tick();
    tick();
    s_ack = 1'b1; s_err = 1'b1; s_dat_r = 32'hDEAD_BEEF;
    tick();
    s_ack = 1'b0; s_err = 1'b0;
    idle_m();
    tick();

    req(1'b0, 32'h400, 32'h0, 4'hf);
    tick();
    tick();
    idle_m();
    s_ack = 1'b1; s_dat_r = 32'h1111_1111;
    tick();
    s_ack = 1'b0;
    chk("t4_cyc_c3", s_cyc, 1'b0);
    chk("t4_busy_c3", busy, 1'b0);
    tick(); tick(); tick();
    t0 = cyc_n;
    req(1'b0, 32'h404, 32'h0, 4'hf);
    push(1'b0, 32'h0BAD_F00D, 1'b1, t0 + 2);
    tick();
    chk("t4_next_stb", s_stb, 1'b1);
    s_ack = 1'b1; s_dat_r = 32'h0BAD_F00D;
    tick();
    s_ack = 1'b0;
    idle_m();
    tick();

`ifdef WBI_TIMEOUT_EN
    t0 = cyc_n;
    req(1'b0, 32'h500, 32'h0, 4'hf);
    push(1'b1, 32'hFFFF_FFFF, 1'b1, t0 + 9);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t5_stb_req", s_stb, 1'b1);
    end
    tick();
    chk("t5_stb_drop", s_stb, 1'b0);
    idle_m();
    tick();
`else
    req(1'b0, 32'h500, 32'h0, 4'hf);
    low = 0;
    repeat (1000) begin
      tick();
      if (busy !== 1'b1) low++;
    end
    chk("t5_busy_held", low, 0);
    chk("t5_stb_held", s_stb, 1'b1);
    idle_m();
    tick();
    chk("t5_abort_busy", busy, 1'b0);
`endif

    req(1'b0, 32'h600, 32'h0, 4'hf);
    tick();
    chk("t6_stb_req", s_stb, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_ctl", {27'd0, busy, s_cyc, s_stb, m_ack, m_err}, 32'd0);
    chk("t6_rst_adr", s_adr, 32'd0);
    chk("t6_rst_dat", m_dat, 32'd0);
    idle_m();
    tick(); tick();
    rstn = 1'b1;
    tick();
    t0 = cyc_n;
    req(1'b0, 32'h100, 32'h0, 4'hf);
    push(1'b0, 32'hC3C3_3C3C, 1'b1, t0 + 2);
    tick();
    s_ack = 1'b1; s_dat_r = 32'hC3C3_3C3C;
    tick();
    s_ack = 1'b0;
    idle_m();
    tick(); tick();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
